register_file: RTL and testbench



---
 rtl/register_file.sv | 56 +++++
 tb/tb_register_file.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32x32-bit register file for a dual-issue datapath: four combinational read ports, two synchronous write ports.
// r0 reads as zero. On a same-address write, the companion (younger) lane wins.
module register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        regWrite,
  input  logic        regWrite_c,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs_c,
  input  logic [4:0]  rt_c,
  input  logic [4:0]  rd_c,
  input  logic [31:0] writeData,
  input  logic [31:0] writeData_c,
  output logic [31:0] rsOut,
  output logic [31:0] rtOut,
  output logic [31:0] rsOut_c,
  output logic [31:0] rtOut_c
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        always_comb regs_d[gi] = '0;
      end else begin : g_gpr
        // The companion lane is evaluated last, so it overrides the primary lane on a collision.
        always_comb begin
          regs_d[gi] = regs_q[gi];
          if (regWrite && (rd == 5'(gi)))
            regs_d[gi] = writeData;
          if (regWrite_c && (rd_c == 5'(gi)))
            regs_d[gi] = writeData_c;
        end
      end

      always_ff @(posedge clk) begin
        if (reset)
          regs_q[gi] <= '0;
        else
          regs_q[gi] <= regs_d[gi];
      end
    end
  endgenerate

  // Address 0 is forced to zero so r0 is zero even before the first reset edge.
  assign rsOut   = (rs   == 5'd0) ? 32'h0 : regs_q[rs];
  assign rtOut   = (rt   == 5'd0) ? 32'h0 : regs_q[rt];
  assign rsOut_c = (rs_c == 5'd0) ? 32'h0 : regs_q[rs_c];
  assign rtOut_c = (rt_c == 5'd0) ? 32'h0 : regs_q[rt_c];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Expected values are hand-computed constants.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite, regWrite_c;
  logic [4:0]  rs, rt, rd, rs_c, rt_c, rd_c;
  logic [31:0] writeData, writeData_c;
  logic [31:0] rsOut, rtOut, rsOut_c, rtOut_c;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk         (clk),
    .reset       (reset),
    .regWrite    (regWrite),
    .regWrite_c  (regWrite_c),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .rs_c        (rs_c),
    .rt_c        (rt_c),
    .rd_c        (rd_c),
    .writeData   (writeData),
    .writeData_c (writeData_c),
    .rsOut       (rsOut),
    .rtOut       (rtOut),
    .rsOut_c     (rsOut_c),
    .rtOut_c     (rtOut_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      $display("check %s: got %h", tag, observed);
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Commit one rising edge, then let the outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; regWrite = 1'b0; regWrite_c = 1'b0;
    rs = '0; rt = '0; rd = '0; rs_c = '0; rt_c = '0; rd_c = '0;
    writeData = '0; writeData_c = '0;
    @(negedge clk);

    // Reset takes priority over a write in the same edge.
    reset = 1'b1; regWrite = 1'b1; rd = 5'd15; writeData = 32'hAC0AC0AC;
    tick();
    reset = 1'b0; regWrite = 1'b0;
    rs = 5'd15; rt = 5'd31; rs_c = 5'd1; rt_c = 5'd15;
    #1;
    check("reset_rs15", rsOut, 32'h0);
    check("reset_rt31", rtOut, 32'h0);
    check("reset_rsc1", rsOut_c, 32'h0);
    check("reset_rtc15", rtOut_c, 32'h0);

    // Primary write: old value is visible until the edge.
    @(negedge clk);
    regWrite = 1'b1; rd = 5'd13; writeData = 32'hAC0AC0AC;
    rs = 5'd13; rt_c = 5'd13;
    #1;
    check("pre_edge_rs13", rsOut, 32'h0);
    check("pre_edge_rtc13", rtOut_c, 32'h0);
    tick();
    regWrite = 1'b0;
    #1;
    check("prim_rs13", rsOut, 32'hAC0AC0AC);
    check("prim_rtc13", rtOut_c, 32'hAC0AC0AC);

    // Companion write; primary data must not land while regWrite is low.
    @(negedge clk);
    regWrite_c = 1'b1; rd_c = 5'd9; writeData_c = 32'h87654321;
    regWrite = 1'b0; rd = 5'd3; writeData = 32'hDEADBEEF;
    tick();
    regWrite_c = 1'b0;
    rs_c = 5'd9; rt = 5'd9; rs = 5'd3;
    #1;
    check("comp_rsc9", rsOut_c, 32'h87654321);
    check("comp_rt9", rtOut, 32'h87654321);
    check("comp_no_prim_r3", rsOut, 32'h0);

    // Dual write to distinct targets.
    @(negedge clk);
    regWrite = 1'b1; rd = 5'd6; writeData = 32'hAC8AC8AC;
    regWrite_c = 1'b1; rd_c = 5'd7; writeData_c = 32'hDEFDEFDE;
    tick();
    regWrite = 1'b0; regWrite_c = 1'b0;
    rs = 5'd6; rt = 5'd7; rs_c = 5'd7; rt_c = 5'd6;
    #1;
    check("dual_rs6", rsOut, 32'hAC8AC8AC);
    check("dual_rt7", rtOut, 32'hDEFDEFDE);
    check("dual_rsc7", rsOut_c, 32'hDEFDEFDE);
    check("dual_rtc6", rtOut_c, 32'hAC8AC8AC);

    // Collision: companion lane wins.
    @(negedge clk);
    regWrite = 1'b1; rd = 5'd7; writeData = 32'h11111111;
    regWrite_c = 1'b1; rd_c = 5'd7; writeData_c = 32'hDEDEABAB;
    tick();
    regWrite = 1'b0; regWrite_c = 1'b0;
    rs = 5'd7; rt_c = 5'd6;
    #1;
    check("collide_rs7", rsOut, 32'hDEDEABAB);
    check("collide_r6_kept", rtOut_c, 32'hAC8AC8AC);

    // Writes to r0 from both lanes are discarded.
    @(negedge clk);
    regWrite = 1'b1; rd = 5'd0; writeData = 32'hFFFFFFFF;
    regWrite_c = 1'b1; rd_c = 5'd0; writeData_c = 32'h12345678;
    tick();
    regWrite = 1'b0; regWrite_c = 1'b0;
    rs = 5'd0; rt = 5'd0; rs_c = 5'd0; rt_c = 5'd0;
    #1;
    check("r0_rs", rsOut, 32'h0);
    check("r0_rt", rtOut, 32'h0);
    check("r0_rsc", rsOut_c, 32'h0);
    check("r0_rtc", rtOut_c, 32'h0);

    // Hold with enables low over several edges.
    @(negedge clk);
    rd = 5'd13; writeData = 32'h0BADF00D; rd_c = 5'd9; writeData_c = 32'h0BADF00D;
    repeat (4) tick();
    rs = 5'd13; rt = 5'd9; rs_c = 5'd7;
    #1;
    check("hold_r13", rsOut, 32'hAC0AC0AC);
    check("hold_r9", rtOut, 32'h87654321);
    check("hold_r7", rsOut_c, 32'hDEDEABAB);

    // Mid-operation reset discards pending writes and clears everything.
    @(negedge clk);
    reset = 1'b1;
    regWrite = 1'b1; rd = 5'd20; writeData = 32'h55555555;
    regWrite_c = 1'b1; rd_c = 5'd21; writeData_c = 32'hAAAAAAAA;
    tick();
    reset = 1'b0; regWrite = 1'b0; regWrite_c = 1'b0;
    rs = 5'd20; rt = 5'd21; rs_c = 5'd13; rt_c = 5'd7;
    #1;
    check("mid_reset_r20", rsOut, 32'h0);
    check("mid_reset_r21", rtOut, 32'h0);
    check("mid_reset_r13", rsOut_c, 32'h0);
    check("mid_reset_r7", rtOut_c, 32'h0);

    // Highest address after reset.
    @(negedge clk);
    regWrite = 1'b1; rd = 5'd31; writeData = 32'hCAFEBABE;
    tick();
    regWrite = 1'b0;
    rt_c = 5'd31;
    #1;
    check("r31_rtc", rtOut_c, 32'hCAFEBABE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
